// File: rtl/pcm_capture_ctrl_pkg.sv
// pcm_capture_ctrl_pkg: shared defaults and FSM state encoding for the PCM capture path
package pcm_capture_ctrl_pkg;
    localparam int CIC_W          = 22;
    localparam int PCM_OW         = 16;
    localparam int FIFO_DEPTH     = 4;
    localparam int WARMUP_STROBES = 8;
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;
endpackage

// File: rtl/pcm_capture_ctrl_fifo.sv
// audio_frame_fifo: stereo frame FIFO; push and pop together on full are both honoured
module audio_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic wr_en, rd_en;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    // storage is not reset; the pointers alone decide what is visible
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end
    // pointer advance; the extra msb distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/pcm_capture_ctrl.sv
// pcm_capture_ctrl: gates the mic, skips CIC warmup, scales/saturates and buffers stereo PCM (PCM_OVF_COUNT_EN adds ovf_cnt)
module pcm_capture_ctrl
    import pcm_capture_ctrl_pkg::*;
#(
    parameter int W      = CIC_W,
    parameter int OW     = PCM_OW,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int WARMUP = WARMUP_STROBES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [2:0]          shift,
    input  logic                en_pcm,
    input  logic signed [W-1:0] pcm_left,
    input  logic signed [W-1:0] pcm_right,
    output logic                mic_run,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OW-1:0]       out_left,
    output logic [OW-1:0]       out_right,
    output logic                ovf,
`ifdef PCM_OVF_COUNT_EN
    output logic [15:0]         ovf_cnt,
`endif
    output logic                busy
);
    localparam int WCW = $clog2(WARMUP + 1);
    localparam logic signed [W-1:0] MAXV = W'((1 << (OW-1)) - 1);
    localparam logic signed [W-1:0] MINV = ~MAXV;
    function automatic logic [OW-1:0] sat(input logic signed [W-1:0] v);
        return (v > MAXV) ? {1'b0, {(OW-1){1'b1}}} : (v < MINV) ? {1'b1, {(OW-1){1'b0}}} : v[OW-1:0];
    endfunction
    state_t state;
    logic [WCW-1:0] warm_cnt;
    logic push, pop, full, empty, drop;
    logic signed [W-1:0] sl, sr;
    logic [2*OW-1:0] head;
    assign sl        = pcm_left >>> shift;
    assign sr        = pcm_right >>> shift;
    assign push      = (state == ST_RUN) && en_pcm;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && full && !pop;
    assign out_left  = head[2*OW-1:OW];
    assign out_right = head[OW-1:0];
    audio_frame_fifo #(.WIDTH(2*OW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({sat(sl), sat(sr)}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
    // capture sequencing with registered mic_run/busy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_OFF;
            warm_cnt <= '0;
            mic_run  <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                ST_OFF: if (enable) begin
                    state    <= ST_WARMUP;
                    warm_cnt <= '0;
                    mic_run  <= 1'b1;
                    busy     <= 1'b1;
                    ovf      <= 1'b0;
                end
                ST_WARMUP: if (!enable) begin
                    state   <= ST_DRAIN;
                    mic_run <= 1'b0;
                end else if (en_pcm) begin
                    if (warm_cnt == WCW'(WARMUP - 1)) begin
                        state    <= ST_RUN;
                        warm_cnt <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + WCW'(1);
                    end
                end
                ST_RUN: if (!enable) begin
                    state   <= ST_DRAIN;
                    mic_run <= 1'b0;
                end
                default: if (empty) begin
                    state <= ST_OFF;
                    busy  <= 1'b0;
                end
            endcase
            if (drop) ovf <= 1'b1;
        end
    end
`ifdef PCM_OVF_COUNT_EN
    // dropped-frame counter, saturating, cleared together with ovf
    always_ff @(posedge clk) begin
        if (rst || (state == ST_OFF && enable)) ovf_cnt <= '0;
        else if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pcm_capture_ctrl.sv
// tb_pcm_capture_ctrl: directed scoreboard bench for pcm_capture_ctrl
module tb_pcm_capture_ctrl;
    logic clk = 1'b0;
    logic rst, enable, en_pcm, out_ready;
    logic [2:0] shift;
    logic signed [21:0] pcm_left, pcm_right;
    logic mic_run, out_valid, ovf, busy;
    logic [15:0] out_left, out_right;
`ifdef PCM_OVF_COUNT_EN
    logic [15:0] ovf_cnt;
`endif
    int checks = 0;
    int failures = 0;
    logic [31:0] q[$];
    logic model_ovf = 1'b0;
    int model_drops = 0;

    always #5 clk = ~clk;

    pcm_capture_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .shift     (shift),
        .en_pcm    (en_pcm),
        .pcm_left  (pcm_left),
        .pcm_right (pcm_right),
        .mic_run   (mic_run),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_left  (out_left),
        .out_right (out_right),
        .ovf       (ovf),
`ifdef PCM_OVF_COUNT_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat_m(input logic signed [21:0] x, input int sh);
        longint v;
        v = longint'(x) >>> sh;
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    // one clock: check handshake against the model, apply the expected push, advance past the edge
    task automatic tick(input logic exp_push, input logic [31:0] frame);
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (out_ready && q.size() != 0) begin
            check("frame", {out_left, out_right}, q[0]);
            void'(q.pop_front());
        end
        if (exp_push) begin
            if (q.size() < 4) q.push_back(frame);
            else begin
                model_ovf = 1'b1;
                model_drops++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic signed [21:0] l, input logic signed [21:0] r, input logic exp_push, input logic [31:0] frame);
        pcm_left = l;
        pcm_right = r;
        en_pcm = 1'b1;
        tick(exp_push, frame);
        en_pcm = 1'b0;
    endtask

    task automatic push_m(input logic signed [21:0] l, input logic signed [21:0] r);
        strobe(l, r, 1'b1, {sat_m(l, int'(shift)), sat_m(r, int'(shift))});
    endtask

    task automatic drain_all();
        for (int i = 0; i < 20 && q.size() != 0; i++) tick(1'b0, '0);
        check("drain_done", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; en_pcm = 1'b0; out_ready = 1'b1; shift = 3'd0;
        pcm_left = '0; pcm_right = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mic_run", {31'd0, mic_run}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        check("rst_out", {out_left, out_right}, 0);
        rst = 1'b0;
        tick(1'b0, '0);
        check("off_idle_mic_run", {31'd0, mic_run}, 0);
        enable = 1'b1;
        tick(1'b0, '0);
        check("mic_run_on", {31'd0, mic_run}, 1);
        check("busy_on", {31'd0, busy}, 1);
        for (int i = 0; i < 8; i++) begin
            strobe(22'sd1000 + 22'(i), -22'sd1000, 1'b0, '0);
            tick(1'b0, '0);
        end
        push_m(22'sd100, -22'sd100);
        push_m(22'sd200, 22'sd7);
        tick(1'b0, '0);
        push_m(-22'sd300, 22'sd30000);
        push_m(22'sd40000, -22'sd40000);
        drain_all();
        strobe(22'h0FFFFF, -22'sd1048576, 1'b1, {16'h7FFF, 16'h8000});
        shift = 3'd5;
        strobe(22'h0FFFFF, -22'sd1048576, 1'b1, {16'h7FFF, 16'h8000});
        shift = 3'd3;
        strobe(22'sd2048, -22'sd2048, 1'b1, {16'd256, 16'hFF00});
        shift = 3'd1;
        push_m(22'sd70000, -22'sd65537);
        drain_all();
        out_ready = 1'b0;
        shift = 3'd0;
        for (int i = 0; i < 5; i++) push_m(22'sd10 * 22'(i + 1), -22'sd5 * 22'(i + 1));
        check("ovf_set", {31'd0, ovf}, {31'd0, model_ovf});
`ifdef PCM_OVF_COUNT_EN
        check("ovf_cnt_1", {16'd0, ovf_cnt}, model_drops);
`endif
        out_ready = 1'b1;
        push_m(22'sd777, -22'sd777);
`ifdef PCM_OVF_COUNT_EN
        check("ovf_cnt_pushpop", {16'd0, ovf_cnt}, model_drops);
`endif
        drain_all();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_m(22'sd5000 + 22'(i), 22'sd12);
        enable = 1'b0;
        tick(1'b0, '0);
        check("drain_mic_run", {31'd0, mic_run}, 0);
        check("drain_busy", {31'd0, busy}, 1);
        strobe(22'sd999, 22'sd999, 1'b0, '0);
        out_ready = 1'b1;
        drain_all();
        tick(1'b0, '0);
        check("off_busy", {31'd0, busy}, 0);
        enable = 1'b1;
        tick(1'b0, '0);
        model_ovf = 1'b0;
        check("reenable_ovf_clr", {31'd0, ovf}, {31'd0, model_ovf});
        for (int i = 0; i < 8; i++) strobe(22'sd1, 22'sd1, 1'b0, '0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_m(22'sd20 + 22'(i), 22'sd0);
        check("ovf_before_rst", {31'd0, ovf}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        model_ovf = 1'b0;
        check("rst_mid_valid", {31'd0, out_valid}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_ovf", {31'd0, ovf}, {31'd0, model_ovf});
        out_ready = 1'b1;
        tick(1'b0, '0);
        check("rewarm_mic_run", {31'd0, mic_run}, 1);
        for (int i = 0; i < 8; i++) strobe(22'sd3, 22'sd3, 1'b0, '0);
        tick(1'b0, '0);
        push_m(22'sd1234, -22'sd4321);
        drain_all();
        tick(1'b0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
